// File: rtl/mux4_rr_stream_if.sv
// Stream bundle between four producers, one consumer and the round-robin merge.
// The master modport is the environment side; the slave modport is the mux.
interface mux4_rr_stream_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux4_rr_stream.sv
// 4-to-1 round-robin stream merge with a registered, channel-tagged output word.
// The output register drains and reloads in the same edge for full throughput.
module mux4_rr_stream #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  mux4_rr_stream_if.slave    bus
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       sel_q, sel_d;

  logic             load_en;
  logic             grant_valid;
  logic [1:0]       grant;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] grant_data;

  assign load_en = (state_q == EMPTY) || bus.out_ready;

  // Search starts just after the previous winner, so last_q itself is tried last.
  always_comb begin
    logic [1:0] idx;
    grant_valid = 1'b0;
    grant       = 2'd0;
    idx         = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!grant_valid && bus.in_valid[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (load_en && grant_valid && !rst) begin
      in_ready = 4'b0001 << grant;
    end
  end

  always_comb begin
    case (grant)
      2'd0:    grant_data = bus.in_data0;
      2'd1:    grant_data = bus.in_data1;
      2'd2:    grant_data = bus.in_data2;
      default: grant_data = bus.in_data3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (load_en) begin
      if (grant_valid) begin
        state_d = FULL;
        last_d  = grant;
        data_d  = grant_data;
        sel_d   = grant;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // last resets to 3 so channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      last_q  <= 2'd3;
      data_q  <= '0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: doc/mux4_rr_stream.md
# mux4_rr_stream

4-to-1 round-robin stream multiplexer with valid/ready handshakes. It merges four independent producer channels onto one registered output stream. Each output word carries a 2-bit channel tag (`out_sel`), which the downstream 1:4 demultiplexer uses to route the word back to the matching lane. It is the transmit/merge end of the channel-select interface; the demultiplexer is the receive/split end.

## Interface
- `WIDTH`, default 8: data width of every channel and of the output.
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_valid`, input, 4: bit i set means channel i presents a word.
- `in_ready`, output, 4: bit i set means channel i's word is accepted this cycle.
- `in_data0` .. `in_data3`, input, WIDTH each: channel payloads.
- `out_valid`, output, 1: the output register holds a word.
- `out_ready`, input, 1: the consumer accepts the output word this cycle.
- `out_data`, output, WIDTH: registered payload.
- `out_sel`, output, 2: registered source channel index of `out_data`.

## Operation
- State is a one-bit output-register state, EMPTY or FULL, which is the same as `out_valid`. A 2-bit `last` pointer holds the most recent grant.
- `load_en = !out_valid || out_ready`. This is combinational.
- Arbitration is combinational when `load_en` is 1 and any `in_valid` bit is set:
  - Search channels in the order `last+1`, `last+2`, `last+3`, `last` (mod 4).
  - The first channel with `in_valid` set wins.
- `in_ready[g]` = 1 only for the winning channel g, and only when `load_en` is 1. All other bits are 0.
  - At most one `in_ready` bit is 1 in any cycle.
  - A handshake on channel i is the cycle where `in_valid[i]` and `in_ready[i]` are both 1.
- On a handshake with channel g, at the clock edge:
  - `out_data` <= `in_data`g.
  - `out_sel` <= g.
  - `out_valid` <= 1.
  - `last` <= g.
- When `load_en` is 1 and no channel is valid: if `out_valid` was 1, it clears to 0 (the drain case). `out_data`, `out_sel` and `last` hold.
- When `out_valid` is 1 and `out_ready` is 0 (FULL, stalled):
  - `out_data`, `out_sel` and `out_valid` stay stable.
  - All `in_ready` bits are 0.
  - `last` holds.
- Simultaneous drain and load (FULL, `out_ready` = 1, some channel valid): the new word replaces the old in the same edge. `out_valid` stays 1, so a sustained rate of one word per cycle is possible.
- State transitions:
  - EMPTY to FULL when any channel is valid.
  - FULL stays FULL when stalled, or when drained and reloaded.
  - FULL to EMPTY when drained with no channel valid.
- Producers may drop `in_valid` without a handshake. The arbiter re-evaluates every cycle, and the grant is not sticky.
- Payloads are passed through unmodified. There is no width conversion.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `out_sel` = 2'b00, `last` = 2'b11. With `last` = 3, channel 0 has top priority after reset.
- Reset mid-operation: any word held in the output register is discarded. `in_ready` is forced to 0 during the reset cycle.
- Latency: a word accepted at edge N appears on `out_data`/`out_valid` after edge N, i.e. it is visible in cycle N+1.
- `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready` and `last`.
- `out_*` are pure register outputs. There is no combinational path from inputs to `out_*`.
- Fairness: with all four channels continuously valid and `out_ready` = 1, grants rotate 0,1,2,3,0,… A channel that is continuously valid is granted within 4 accepting cycles.
- Throughput: one word per cycle whenever `out_ready` = 1 and at least one channel is valid.

## Test plan
- Reset, then `in_valid` = 4'b0000 for 3 cycles -> `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `in_ready` = 0 throughout.
- Only channel 2 valid with `in_data2` = 8'hA5, `out_ready` = 1 -> `in_ready` = 4'b0100 in cycle 0. In cycle 1, `out_valid` = 1, `out_data` = 8'hA5, `out_sel` = 2.
- All channels valid with data 8'h10/8'h11/8'h12/8'h13, `out_ready` held at 1 for 8 cycles -> `out_sel` sequence is 0,1,2,3,0,1,2,3 with matching data, and `out_valid` is continuously 1.
- FULL holding `out_sel` = 1, `out_data` = 8'h11, then `out_ready` = 0 for 5 cycles with all channels valid -> outputs stay frozen and `in_ready` = 0. Then `out_ready` = 1 -> the next grant is channel 2.
- Single word from channel 3 (8'h3C), then `in_valid` = 0 and `out_ready` = 1 -> `out_valid` is 1 for exactly one cycle, then 0. `out_data` holds 8'h3C.
- Assert `rst` for one cycle while FULL with pending `out_data` = 8'h77 -> next cycle `out_valid` = 0 and `out_data` = 0. The first grant after reset goes to channel 0 when all channels are valid.
